pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: ripple-carry adder split into STAGES chunk-wide pipeline stages
// with a valid/ready handshake. The whole pipeline advances as one unit
// whenever the output register is empty or being consumed.
//
// Optional feature: define PIPE_ADDER_OVF_EN to add the `ovf` output, which
// flags two's-complement overflow of the delivered sum.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CH = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_err
    $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
  end

  // Global advance: a stalled output freezes every stage so nothing is lost.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Inputs to this stage: raw ports for stage 0, previous stage otherwise.
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, v_in;
    logic [CH:0]      chunk;
    logic [WIDTH-1:0] s_nxt;
    // Stage registers. Operands travel whole so later chunks stay aligned
    // with their transaction; completed sum chunks accumulate in s_p.
    logic [WIDTH-1:0] a_p, b_p, s_p;
    logic             c_p, vld_p;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b;
      assign s_in = '0;
      assign c_in = cin;
      assign v_in = in_valid;
    end else begin : g_link
      assign a_in = g_stg[k-1].a_p;
      assign b_in = g_stg[k-1].b_p;
      assign s_in = g_stg[k-1].s_p;
      assign c_in = g_stg[k-1].c_p;
      assign v_in = g_stg[k-1].vld_p;
    end

    // Chunk k of the addition; the extra top bit is the carry to stage k+1.
    assign chunk = {1'b0, a_in[k*CH +: CH]} + {1'b0, b_in[k*CH +: CH]}
                 + {{CH{1'b0}}, c_in};

    // Splice the new chunk into the partial sum carried from earlier stages.
    always_comb begin
      s_nxt = s_in;
      s_nxt[k*CH +: CH] = chunk[CH-1:0];
    end

    // Stage valid bit: cleared by reset, moves with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
      end else if (adv) begin
        vld_p <= v_in;
      end
    end

    // Operand skew registers: data only, no reset needed.
    always_ff @(posedge clk) begin
      if (adv) begin
        a_p <= a_in;
        b_p <= b_in;
      end
    end

    if (k == STAGES-1) begin : g_tail
      // Final stage drives sum/carry directly, so it must clear on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_p <= '0;
          c_p <= 1'b0;
        end else if (adv) begin
          s_p <= s_nxt;
          c_p <= chunk[CH];
        end
      end
    end else begin : g_mid
      // Intermediate partial sum and chunk carry.
      always_ff @(posedge clk) begin
        if (adv) begin
          s_p <= s_nxt;
          c_p <= chunk[CH];
        end
      end
    end
  end

  // ---- output stage boundary ----
  assign out_valid = g_stg[STAGES-1].vld_p;
  assign sum       = g_stg[STAGES-1].s_p;
  assign carry     = g_stg[STAGES-1].c_p;

  // The last stage's operand copy only matters for its sign bits (overflow);
  // the remaining bits are dropped here on purpose.
  logic unused_ops;
  assign unused_ops = ^{g_stg[STAGES-1].a_p, g_stg[STAGES-1].b_p};

`ifdef PIPE_ADDER_OVF_EN
  // Overflow: operands share a sign and the result sign differs. Gated by
  // out_valid so it reads 0 in reset and is held under stall with sum.
  assign ovf = out_valid
             && (g_stg[STAGES-1].a_p[WIDTH-1] == g_stg[STAGES-1].b_p[WIDTH-1])
             && (sum[WIDTH-1] != g_stg[STAGES-1].a_p[WIDTH-1]);
`endif

endmodule
